apb_master_arbiter: RTL

- Two-requester APB master: arbitrates two simple request/response ports (CPU data port and debug/DMA port) onto one APB bus.
- Drives APB SETUP/ACCESS phases and decodes the address to one of four PSEL lines (slot 1 = GPIO peripheral).
- Waits on per-slave PREADY and returns read data or an error to the granted requester.

---
 rtl/apb_master_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_arbiter.sv
// Two-port APB master: arbitrates a CPU port and a debug/DMA port onto one APB bus,
// decodes a 16 KiB window into four PSEL lines and returns data or error per requester.
module apb_master_arbiter #(
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    output logic [31:0] req0_rdata,
    output logic        req0_err,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic [31:0] req1_rdata,
    output logic        req1_err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic [3:0]  PSEL,
    output logic        PENABLE,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [3:0]  PREADY
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t           state, state_nxt;
    logic             grant, grant_nxt;
    logic             last_grant, last_grant_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      data_q, data_nxt;
    logic             pend, pend_nxt;
    logic             latch, fire, fire_err;
    logic [31:0]      fire_data;
    logic             pick;
    logic [31:0]      sel_addr, sel_wdata;
    logic             sel_write;
    logic [1:0]       idx;
    logic [31:0]      prdata_mux;
    logic             busy;

    assign pick      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    assign sel_addr  = pick ? req1_addr  : req0_addr;
    assign sel_wdata = pick ? req1_wdata : req0_wdata;
    assign sel_write = pick ? req1_write : req0_write;
    assign idx       = PADDR[13:12];
    // A requester still shows its old valid during its ready cycle; never regrant it then.
    assign busy      = req0_ready | req1_ready;

    assign PSEL    = (state == SETUP || state == ACCESS) ? (4'b0001 << idx) : 4'b0000;
    assign PENABLE = (state == ACCESS);

    always_comb begin
        case (idx)
            2'd0:    prdata_mux = PRDATA0;
            2'd1:    prdata_mux = PRDATA1;
            2'd2:    prdata_mux = PRDATA2;
            default: prdata_mux = PRDATA3;
        endcase
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        cnt_nxt        = cnt;
        data_nxt       = data_q;
        pend_nxt       = pend;
        latch          = 1'b0;
        fire           = 1'b0;
        fire_err       = 1'b0;
        fire_data      = '0;
        case (state)
            IDLE: begin
                if ((req0_valid || req1_valid) && !busy) begin
                    latch          = 1'b1;
                    grant_nxt      = pick;
                    last_grant_nxt = pick;
                    if (sel_addr[31:14] != BASE_ADDR[31:14]) begin
                        fire      = 1'b1;
                        fire_err  = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_nxt   = '0;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (PREADY[idx]) begin
                    data_nxt  = PWRITE ? 32'd0 : prdata_mux;
                    pend_nxt  = 1'b1;
                    state_nxt = RESP;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fire      = 1'b1;
                    fire_err  = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            RESP: begin
                // Successful completions pulse ready on leaving RESP; errors pulsed on entry.
                fire      = pend;
                fire_data = data_q;
                pend_nxt  = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            data_q     <= '0;
            pend       <= 1'b0;
            PADDR      <= '0;
            PWDATA     <= '0;
            PWRITE     <= 1'b0;
            req0_ready <= 1'b0;
            req0_rdata <= '0;
            req0_err   <= 1'b0;
            req1_ready <= 1'b0;
            req1_rdata <= '0;
            req1_err   <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            cnt        <= cnt_nxt;
            data_q     <= data_nxt;
            pend       <= pend_nxt;
            if (latch) begin
                PADDR  <= sel_addr;
                PWDATA <= sel_wdata;
                PWRITE <= sel_write;
            end
            req0_ready <= fire && !grant_nxt;
            req0_rdata <= (fire && !grant_nxt) ? fire_data : 32'd0;
            req0_err   <= fire && !grant_nxt && fire_err;
            req1_ready <= fire && grant_nxt;
            req1_rdata <= (fire && grant_nxt) ? fire_data : 32'd0;
            req1_err   <= fire && grant_nxt && fire_err;
        end
    end
endmodule
